// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit
// Purpose  : Execute-stage branch resolver with a 2-bit BHT for fetch
//            prediction. Define BRA_STATS_EN for branch/mispredict counters.
// Revision : 1.0
// ============================================================================
module branch_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    input  logic            in_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [2:0]      br_type,
    input  logic [6:0]      op_code,
    input  logic [XLEN-1:0] in_01,
    input  logic [XLEN-1:0] in_02,
    input  logic            pred_taken,
    input  logic            flush,
    output logic            out_valid,
    output logic            bra_taken,
    output logic            mispredict
`ifdef BRA_STATS_EN
    ,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
`endif
);

    localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] BT_EQ  = 3'b000;
    localparam logic [2:0] BT_NE  = 3'b001;
    localparam logic [2:0] BT_LT  = 3'b010;
    localparam logic [2:0] BT_GE  = 3'b011;
    localparam logic [2:0] BT_LTU = 3'b100;
    localparam logic [2:0] BT_GEU = 3'b101;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // ------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------
    logic [1:0]       bht_q [BHT_DEPTH];
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_d;
    logic             bht_we;

    // PC bits outside the index slice play no part in prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc[XLEN-1:IDX_W+2], pc[1:0],
                              f_pc[XLEN-1:IDX_W+2], f_pc[1:0]};

    assign f_idx        = f_pc[IDX_W+1:2];
    assign ex_idx       = pc[IDX_W+1:2];
    assign f_pred_taken = bht_q[f_idx][1];
    assign ctr_cur      = bht_q[ex_idx];

    // ------------------------------------------------------------------
    // Direction resolution
    // ------------------------------------------------------------------
    logic is_cond;
    logic is_jump;
    logic cmp_eq;
    logic cmp_lt;
    logic cmp_ltu;
    logic cond_taken;
    logic res_taken;
    logic accept;

    assign is_cond = (op_code == OP_BRANCH);
    assign is_jump = (op_code == OP_JAL) || (op_code == OP_JALR);
    assign cmp_eq  = (in_01 == in_02);
    assign cmp_lt  = ($signed(in_01) < $signed(in_02));
    assign cmp_ltu = (in_01 < in_02);

    always_comb begin
        cond_taken = 1'b0;
        case (br_type)
            BT_EQ:   cond_taken = cmp_eq;
            BT_NE:   cond_taken = !cmp_eq;
            BT_LT:   cond_taken = cmp_lt;
            BT_GE:   cond_taken = !cmp_lt;
            BT_LTU:  cond_taken = cmp_ltu;
            BT_GEU:  cond_taken = !cmp_ltu;
            default: cond_taken = 1'b0;
        endcase
    end

    assign res_taken = is_jump || (is_cond && cond_taken);
    assign accept    = in_valid && !flush;
    assign bht_we    = accept && is_cond;

    always_comb begin
        ctr_d = ctr_cur;
        if (res_taken) begin
            if (ctr_cur != CTR_ST) begin
                ctr_d = ctr_cur + 2'd1;
            end
        end else begin
            if (ctr_cur != CTR_SNT) begin
                ctr_d = ctr_cur - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= CTR_WNT;
            end
        end else if (bht_we) begin
            bht_q[ex_idx] <= ctr_d;
        end
    end

    // ------------------------------------------------------------------
    // Result register; taken/mispredict are forced low with valid.
    // ------------------------------------------------------------------
    logic valid_q, valid_d;
    logic taken_q, taken_d;
    logic mis_q,   mis_d;

    assign valid_d = accept;
    assign taken_d = accept && res_taken;
    assign mis_d   = accept && (res_taken ^ pred_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            taken_q <= taken_d;
            mis_q   <= mis_d;
        end
    end

    assign out_valid  = valid_q;
    assign bra_taken  = taken_q;
    assign mispredict = mis_q;

`ifdef BRA_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics, counted from the registered result.
    // ------------------------------------------------------------------
    logic        cond_q, cond_d;
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    assign cond_d = accept && is_cond;

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (valid_q && cond_q && (br_cnt_q != 32'hFFFF_FFFF)) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end
        if (valid_q && mis_q && (mis_cnt_q != 32'hFFFF_FFFF)) begin
            mis_cnt_d = mis_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond_q    <= 1'b0;
            br_cnt_q  <= 32'd0;
            mis_cnt_q <= 32'd0;
        end else begin
            cond_q    <= cond_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign br_count      = br_cnt_q;
    assign mispred_count = mis_cnt_q;
`endif

endmodule
`default_nettype wire
